// File: rtl/ssd_seq_pkg.sv
// Shared types and symbol encodings for the seven-segment sequence entry/check path.
package ssd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_JUDGE,
    ST_DONE_OK,
    ST_DONE_BOOM
  } state_t;

  // Symbols are one-hot-low so a stuck or blank segment pattern never aliases a real symbol.
  localparam logic [3:0] SYM_0 = 4'b1110;
  localparam logic [3:0] SYM_1 = 4'b1101;
  localparam logic [3:0] SYM_2 = 4'b1011;
  localparam logic [3:0] SYM_3 = 4'b0111;

  localparam int STRIKE_W = 3;

  function automatic logic sym_is_valid(input logic [3:0] sym);
    return (sym == SYM_0) || (sym == SYM_1) || (sym == SYM_2) || (sym == SYM_3);
  endfunction

endpackage

// File: rtl/strike_counter.sv
// Saturating strike counter; at_limit stays high once MAX_STRIKES is reached until reset.
module strike_counter
  import ssd_seq_pkg::*;
#(
  parameter int MAX_STRIKES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  output logic [STRIKE_W-1:0] count,
  output logic                at_limit
);

  localparam logic [STRIKE_W-1:0] LIMIT = STRIKE_W'(MAX_STRIKES);

  // Count never wraps: further strikes after the limit are swallowed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/ssd_sequence_checker.sv
// Judges an entered symbol sequence against a latched target and tracks strikes to explosion.
// Optional SSD_CHECKER_EARLY_FAIL_EN: a mismatching entry jumps straight to judging.
module ssd_sequence_checker
  import ssd_seq_pkg::*;
#(
  parameter  int NUM_POS     = 4,
  parameter  int MAX_STRIKES = 3,
  localparam int POS_W       = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NUM_POS-1:0]   sequence_in,
  input  logic [3:0]             entry,
  input  logic                   entry_valid,
  output logic                   busy,
  output logic [POS_W-1:0]       position,
  output logic                   solved,
  output logic                   strike,
  output logic [STRIKE_W-1:0]    strike_count,
  output logic                   defused,
  output logic                   exploded
);

  localparam logic [POS_W-1:0]    LAST_POS     = POS_W'(NUM_POS - 1);
  localparam logic [STRIKE_W-1:0] FINAL_STRIKE = STRIKE_W'(MAX_STRIKES - 1);

  state_t               state_q, state_d;
  logic [4*NUM_POS-1:0] target_q, target_d;
  logic [POS_W-1:0]     position_q, position_d;
  logic                 mismatch_q, mismatch_d;
  logic                 solved_q, solved_d;
  logic                 strike_q, strike_d;
  logic                 defused_q, defused_d;
  logic                 strike_inc;

  logic [3:0]           cur_sym;
  logic                 entry_bad;
  logic                 last_pos;
  logic                 final_strike;

  assign cur_sym      = target_q[4*position_q +: 4];
  assign entry_bad    = (entry != cur_sym) || !sym_is_valid(entry);
  assign last_pos     = (position_q == LAST_POS);
  assign final_strike = (strike_count == FINAL_STRIKE);

  // exploded is the counter's limit flag: it rises on the final strike edge and only reset clears it.
  strike_counter #(
    .MAX_STRIKES (MAX_STRIKES)
  ) u_strike_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (strike_inc),
    .count    (strike_count),
    .at_limit (exploded)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      position_q <= '0;
      mismatch_q <= 1'b0;
      solved_q   <= 1'b0;
      strike_q   <= 1'b0;
      defused_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      position_q <= position_d;
      mismatch_q <= mismatch_d;
      solved_q   <= solved_d;
      strike_q   <= strike_d;
      defused_q  <= defused_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    position_d = position_q;
    mismatch_d = mismatch_q;
    solved_d   = 1'b0;
    strike_d   = 1'b0;
    defused_d  = defused_q;
    strike_inc = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE_OK: begin
        if (start) begin
          target_d   = sequence_in;
          position_d = '0;
          mismatch_d = 1'b0;
          defused_d  = 1'b0;
          state_d    = ST_COLLECT;
        end
      end

      // start is deliberately not decoded here, so a stray start never disturbs a round.
      ST_COLLECT: begin
        if (entry_valid) begin
          mismatch_d = mismatch_q | entry_bad;
`ifdef SSD_CHECKER_EARLY_FAIL_EN
          if (last_pos || entry_bad) begin
`else
          if (last_pos) begin
`endif
            state_d = ST_JUDGE;
          end else begin
            position_d = position_q + 1'b1;
          end
        end
      end

      ST_JUDGE: begin
        if (!mismatch_q) begin
          solved_d  = 1'b1;
          defused_d = 1'b1;
          state_d   = ST_DONE_OK;
        end else begin
          strike_d   = 1'b1;
          strike_inc = 1'b1;
          if (final_strike) begin
            state_d = ST_DONE_BOOM;
          end else begin
            position_d = '0;
            mismatch_d = 1'b0;
            state_d    = ST_COLLECT;
          end
        end
      end

      ST_DONE_BOOM: begin
        state_d = ST_DONE_BOOM;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_COLLECT) || (state_q == ST_JUDGE);
  assign position = position_q;
  assign solved   = solved_q;
  assign strike   = strike_q;
  assign defused  = defused_q;

endmodule

// File: tb/tb_ssd_sequence_checker.sv
// Scoreboard bench for ssd_sequence_checker: stimulus queues expected pulses, a monitor checks them.
module tb_ssd_sequence_checker;
  import ssd_seq_pkg::*;

  localparam int NUM_POS     = 4;
  localparam int MAX_STRIKES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] sequence_in;
  logic [3:0]  entry;
  logic        entry_valid;
  logic        busy;
  logic [1:0]  position;
  logic        solved;
  logic        strike;
  logic [2:0]  strike_count;
  logic        defused;
  logic        exploded;

  typedef struct {
    logic [1:0] kind;
    int         cycle;
    logic [2:0] count;
    logic       defused;
    logic       exploded;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  ssd_sequence_checker #(
    .NUM_POS     (NUM_POS),
    .MAX_STRIKES (MAX_STRIKES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sequence_in  (sequence_in),
    .entry        (entry),
    .entry_valid  (entry_valid),
    .busy         (busy),
    .position     (position),
    .solved       (solved),
    .strike       (strike),
    .strike_count (strike_count),
    .defused      (defused),
    .exploded     (exploded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every solved/strike pulse must match the oldest queued expectation, cycle included.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (solved || strike)) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_pulse: got solved=%0b strike=%0b at cycle %0d, required no pulse",
                 solved, strike, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({solved, strike, strike_count, defused, exploded} !== {e.kind, e.count, e.defused, e.exploded}
            || cyc != e.cycle) begin
          tests_failed++;
          $display("[TB] FAIL pulse: got {solved,strike}=%b count=%0d def=%0b expl=%0b cycle=%0d, required %b count=%0d def=%0b expl=%0b cycle=%0d",
                   {solved, strike}, strike_count, defused, exploded, cyc,
                   e.kind, e.count, e.defused, e.exploded, e.cycle);
        end
      end
    end
  end

  // Level check; exp_pos < 0 means position is not constrained at this point.
  task automatic checkOutput(input string name, input logic exp_busy, input int exp_pos,
                             input logic [2:0] exp_count, input logic exp_def, input logic exp_expl);
    logic [1:0] pos_req;
    logic [7:0] act;
    logic [7:0] req;
    pos_req = (exp_pos < 0) ? position : exp_pos[1:0];
    act = {busy, position, strike_count, defused, exploded};
    req = {exp_busy, pos_req, exp_count, exp_def, exp_expl};
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got busy=%0b pos=%0d count=%0d def=%0b expl=%0b, required busy=%0b pos=%0d count=%0d def=%0b expl=%0b",
               name, busy, position, strike_count, defused, exploded,
               exp_busy, pos_req, exp_count, exp_def, exp_expl);
    end
  endtask

  task automatic checkNoPulse(input string name);
    tests_run++;
    if (solved !== 1'b0 || strike !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got solved=%0b strike=%0b, required 0 0", name, solved, strike);
    end
  endtask

  // Drives one entry from a negedge; holds entry_valid for 'hold' edges and returns the first sampling edge.
  task automatic applyStimulus(input logic [3:0] sym, input logic with_start, input logic [15:0] start_seq,
                               input int hold, output int edge_cyc);
    entry       = sym;
    entry_valid = 1'b1;
    if (with_start) begin
      start       = 1'b1;
      sequence_in = start_seq;
    end
    @(negedge clk);
    edge_cyc = cyc;
    start    = 1'b0;
    for (int h = 1; h < hold; h++) @(negedge clk);
    entry_valid = 1'b0;
  endtask

  task automatic startRound(input logic [15:0] seq);
    sequence_in = seq;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // syms holds position p in bits [4p+3:4p]; kind is {solved,strike} expected one edge after the last entry.
  task automatic enterRound(input logic [15:0] syms, input logic [15:0] tgt, input logic [1:0] kind,
                            input logic [2:0] cnt, input logic def, input logic expl,
                            input logic start_first, input int hold_last);
    int         edge_cyc;
    logic [3:0] s;
    logic [3:0] t;
    exp_t       e;
    edge_cyc = 0;
    for (int p = 0; p < NUM_POS; p++) begin
      s = syms[4*p +: 4];
      t = tgt[4*p +: 4];
      applyStimulus(s, start_first && (p == 0), 16'h0000, (p == NUM_POS-1) ? hold_last : 1, edge_cyc);
`ifdef SSD_CHECKER_EARLY_FAIL_EN
      if (s != t) break;
`else
      if (s != t) edge_cyc = edge_cyc;
`endif
    end
    e = '{kind, edge_cyc + 1, cnt, def, expl};
    exp_q.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_timeout: got %0d pending pulses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int e;
    reset       = 1'b1;
    start       = 1'b0;
    entry_valid = 1'b0;
    entry       = 4'hF;
    sequence_in = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset_levels", 0, 0, 0, 0, 0);
    checkNoPulse("reset_pulses");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] correct entry");
    startRound(16'h7BDE);
    checkOutput("start_busy", 1, 0, 0, 0, 0);
    enterRound(16'h7BDE, 16'h7BDE, 2'b10, 0, 1, 0, 0, 1);
    waitDrain("solve_correct");
    checkOutput("after_solve", 0, -1, 0, 1, 0);

    $display("[TB] wrong symbol then retry");
    startRound(16'h7BDE);
    checkOutput("restart_clears_defused", 1, 0, 0, 0, 0);
    enterRound(16'h77DE, 16'h7BDE, 2'b01, 1, 0, 0, 0, 1);
    waitDrain("wrong_symbol");
    checkOutput("retry_after_strike", 1, 0, 1, 0, 0);
    enterRound(16'h7BDE, 16'h7BDE, 2'b10, 1, 1, 0, 0, 1);
    waitDrain("solve_after_retry");
    checkOutput("after_retry_solve", 0, -1, 1, 1, 0);

    $display("[TB] invalid code");
    startRound(16'h7BDE);
    enterRound(16'h7BD0, 16'h7BDE, 2'b01, 2, 0, 0, 0, 1);
    waitDrain("invalid_code");
    checkOutput("invalid_code_strike", 1, 0, 2, 0, 0);

    $display("[TB] ignored start and held entry_valid");
    enterRound(16'h7BDE, 16'h7BDE, 2'b10, 2, 1, 0, 1, 2);
    waitDrain("ignored_inputs");
    checkOutput("judge_ignores_entry", 0, 3, 2, 1, 0);

    $display("[TB] reset mid-operation");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    startRound(16'h7BDE);
    enterRound(16'hEEEE, 16'h7BDE, 2'b01, 1, 0, 0, 0, 1);
    waitDrain("pre_reset_strike");
    checkOutput("pre_reset_retry", 1, 0, 1, 0, 0);
    applyStimulus(4'hE, 1'b0, 16'h0000, 1, e);
    applyStimulus(4'hD, 1'b0, 16'h0000, 1, e);
    checkOutput("two_entries", 1, 2, 1, 0, 0);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 0, 0, 0, 0, 0);
    checkNoPulse("async_reset_pulses");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    startRound(16'hE7BD);
    checkOutput("new_target_start", 1, 0, 0, 0, 0);
    enterRound(16'hE7BD, 16'hE7BD, 2'b10, 0, 1, 0, 0, 1);
    waitDrain("new_target");
    checkOutput("new_target_solved", 0, -1, 0, 1, 0);

    $display("[TB] explosion");
    startRound(16'h7BDE);
    enterRound(16'h7777, 16'h7BDE, 2'b01, 1, 0, 0, 0, 1);
    waitDrain("boom_strike1");
    checkOutput("boom_retry1", 1, 0, 1, 0, 0);
    enterRound(16'h7777, 16'h7BDE, 2'b01, 2, 0, 0, 0, 1);
    waitDrain("boom_strike2");
    checkOutput("boom_retry2", 1, 0, 2, 0, 0);
    enterRound(16'h7777, 16'h7BDE, 2'b01, 3, 0, 1, 0, 1);
    waitDrain("boom_strike3");
    checkOutput("exploded", 0, -1, 3, 0, 1);
    startRound(16'h7BDE);
    applyStimulus(4'hE, 1'b0, 16'h0000, 1, e);
    applyStimulus(4'h7, 1'b0, 16'h0000, 1, e);
    repeat (3) @(negedge clk);
    checkOutput("boom_ignores_inputs", 0, -1, 3, 0, 1);

    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL final_queue: got %0d pending pulses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ssd_sequence_checker.md
Name: ssd_sequence_checker

Overview:
- Downstream consumer of the seven-segment sequence display/entry stage.
- Latches the 16-bit target sequence at round start, then collects one 4-bit entered symbol per position; the entry stage's next button marks each committed symbol.
- Judges the full entry against the target and issues solved/strike pulses.
- Tracks strikes up to an explode limit and drives the module's defused/exploded status to the top-level bomb controller.

Parameters:
- NUM_POS, 4: number of symbol positions per sequence.
- MAX_STRIKES, 3: strike count that causes explosion (range 1..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches sequence_in and begins a round.
- sequence_in  in  4*NUM_POS  target sequence; position p occupies bits [4p+3:4p].
- entry  in  4  symbol currently selected by the entry stage.
- entry_valid  in  1  one-cycle pulse (next button) committing entry for the current position.
- busy  out  1  high in COLLECT and JUDGE.
- position  out  clog2(NUM_POS)  index of the position awaiting entry.
- solved  out  1  one-cycle pulse on a correct sequence.
- strike  out  1  one-cycle pulse on an incorrect sequence.
- strike_count  out  3  strikes accumulated since reset.
- defused  out  1  level; set on solve.
- exploded  out  1  level; sticky until reset.

Behaviour:
- Valid symbols are one-hot-low: 4'b1110, 4'b1101, 4'b1011, 4'b0111. Any other entry value counts as a mismatch.
- Reset (async, any time, including mid-round):
  - state=IDLE; target=0; position=0; mismatch=0; strike_count=0.
  - busy, solved, strike, defused and exploded are all 0.
- States: IDLE, COLLECT, JUDGE, DONE_OK, DONE_BOOM.
- IDLE or DONE_OK with start=1:
  - Latch target from sequence_in; position=0; mismatch=0; defused=0; go to COLLECT.
  - start is ignored in COLLECT, JUDGE and DONE_BOOM.
- COLLECT with entry_valid=1:
  - mismatch <= mismatch | (entry != target[position]) | !valid(entry).
  - If position==NUM_POS-1, go to JUDGE. Otherwise position increments.
- JUDGE (exactly one cycle; entry_valid ignored):
  - If mismatch=0: solved=1 for one cycle, defused=1, go to DONE_OK.
  - Else: strike=1 for one cycle and strike_count increments.
    - If the new count == MAX_STRIKES: exploded=1, go to DONE_BOOM.
    - Otherwise position=0, mismatch=0, return to COLLECT with the same target (retry).
- Latency: the edge sampling the last entry_valid moves the block to JUDGE. The next edge raises solved or strike. The edge after that clears the pulse.
- DONE_BOOM: terminal until reset; all inputs ignored.
- strike_count saturates at MAX_STRIKES and is never cleared by start.
- position wraps to 0 only through JUDGE; it never exceeds NUM_POS-1.
- entry_valid and start arriving in the same cycle while in COLLECT: the entry is processed and start is ignored.

Optional Feature:
- Macro: SSD_CHECKER_EARLY_FAIL_EN.
- Defined: an entry_valid whose symbol mismatches moves the block to JUDGE immediately, regardless of position, so the strike issues without waiting for the remaining positions.
- Undefined: all NUM_POS entries are always collected before JUDGE.

Decomposition:
- Shared package ssd_seq_pkg holds:
  - state enum;
  - symbol constants SYM_0=4'b1110, SYM_1=4'b1101, SYM_2=4'b1011, SYM_3=4'b0111;
  - sym_is_valid function.
- The display/entry stage also imports these constants.
- One natural sub-module: strike_counter (saturating counter with inc pulse, count output and at_limit flag, parameterised by MAX_STRIKES).

Test Plan:
- Correct entry: reset, start with sequence_in=16'h7BDE, entries E,D,B,7 → solved pulses once 2 edges after the 4th entry; defused=1; strike_count=0; busy=0.
- Wrong symbol: same target, entries E,D,7,7 → strike pulses once; strike_count=1; position=0; busy=1; then entries E,D,B,7 → solved.
- Invalid code: entry 4'b0000 at position 0, then D,B,7 → strike. With SSD_CHECKER_EARLY_FAIL_EN, the strike is instead issued 2 edges after the first entry.
- Explosion: three consecutive wrong rounds with MAX_STRIKES=3 → exploded=1 after the 3rd strike; a later start or entry_valid has no effect; strike_count stays 3.
- Reset mid-operation: assert reset after 2 entries of a round that follows 1 strike → all outputs 0 immediately; after release, start latches a new target and position=0.
- Ignored inputs: start pulsed during COLLECT alongside entry_valid → target unchanged, entry accepted. entry_valid held during JUDGE → no position change.
